// File: rtl/alu_pkg.sv
// Shared opcode map, widths, FSM states and flag helpers for the arbitrated ALU.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 4;
   localparam int NREQ   = 2;

   localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
   localparam logic [OP_W-1:0] OP_ADDI = 4'd1;
   localparam logic [OP_W-1:0] OP_SUB  = 4'd2;
   localparam logic [OP_W-1:0] OP_AND  = 4'd3;
   localparam logic [OP_W-1:0] OP_ANDI = 4'd4;
   localparam logic [OP_W-1:0] OP_OR   = 4'd5;
   localparam logic [OP_W-1:0] OP_SLL  = 4'd6;
   localparam logic [OP_W-1:0] OP_SRL  = 4'd7;
   localparam logic [OP_W-1:0] OP_SRA  = 4'd8;
   localparam logic [OP_W-1:0] OP_SLT  = 4'd9;
   localparam logic [OP_W-1:0] OP_LAST = OP_SLT;

   typedef enum logic {
      ST_IDLE,
      ST_HOLD
   } arb_state_t;

   function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
      return op > OP_LAST;
   endfunction

   function automatic logic is_shift_op(input logic [OP_W-1:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

   // Signed overflow is only meaningful for the add/subtract family.
   function automatic logic calc_ovf(input logic [OP_W-1:0]   op,
                                     input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b,
                                     input logic [DATA_W-1:0] r);
      logic ovf;
      ovf = 1'b0;
      case (op)
         OP_ADD, OP_ADDI: ovf = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
         OP_SUB:          ovf = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
         default:         ovf = 1'b0;
      endcase
      return ovf;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters, the consumer and the arbiter.
interface alu_arbiter_if;
   import alu_pkg::*;

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [OP_W-1:0]   req0_op;
   logic [OP_W-1:0]   req1_op;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;

   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_ovf;
   logic              rsp_err;

   modport master (
      output req_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_ovf, rsp_err
   );

   modport slave (
      input  req_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_ovf, rsp_err
   );

endinterface

// File: rtl/ALU.sv
// Combinational ALU datapath; for shifts, A carries the shift amount and B is shifted.
module ALU
   import alu_pkg::*;
(
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result
);

   always_comb begin
      result = '0;
      case (op)
         OP_ADD, OP_ADDI: result = a + b;
         OP_SUB:          result = a - b;
         OP_AND, OP_ANDI: result = a & b;
         OP_OR:           result = a | b;
         OP_SLL:          result = b << a[4:0];
         OP_SRL:          result = b >> a[4:0];
         OP_SRA:          result = $signed(b) >>> a[4:0];
         OP_SLT:          result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         default:         result = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a held,
// id-tagged response carrying overflow and illegal-opcode flags.
module alu_arbiter
   import alu_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus
);

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic              last_grant;
   logic [NREQ-1:0]   grant;
   logic              can_accept;
   logic              xfer;
   logic              xfer_id;

   logic [OP_W-1:0]   sel_op;
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_b;

   logic [OP_W-1:0]   op_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic              id_q;
   logic [DATA_W-1:0] alu_result;

   // Under contention the port that did not win last time is favoured.
   always_comb begin
      grant = bus.req_valid;
      if (bus.req_valid == 2'b11) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end
   end

   assign can_accept    = (state == ST_IDLE) || bus.rsp_ready;
   assign bus.req_ready = can_accept ? grant : '0;
   assign xfer          = |(bus.req_valid & bus.req_ready);
   assign xfer_id       = grant[1];

   assign sel_op = xfer_id ? bus.req1_op : bus.req0_op;
   assign sel_a  = xfer_id ? bus.req1_a  : bus.req0_a;
   assign sel_b  = xfer_id ? bus.req1_b  : bus.req0_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (xfer) state_nxt = ST_HOLD;
         ST_HOLD: if (bus.rsp_ready && !xfer) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The operand stage doubles as the response register: it only loads on a
   // transfer, so everything derived from it stays stable while held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= OP_ADD;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= 1'b0;
         last_grant <= 1'b1;
      end else if (xfer) begin
         op_q       <= sel_op;
         a_q        <= is_shift_op(sel_op) ? {{(DATA_W-5){1'b0}}, sel_a[4:0]} : sel_a;
         b_q        <= sel_b;
         id_q       <= xfer_id;
         last_grant <= xfer_id;
      end
   end

   ALU u_alu (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (alu_result)
   );

   assign bus.rsp_valid  = (state == ST_HOLD);
   assign bus.rsp_id     = id_q;
   assign bus.rsp_err    = is_illegal_op(op_q);
   assign bus.rsp_result = bus.rsp_err ? '0 : alu_result;
   assign bus.rsp_ovf    = calc_ovf(op_q, a_q, b_q, alu_result);

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU datapath instance between two requesters: port 0 is the main execute path, port 1 is the address/branch unit.
- Each requester uses a valid/ready handshake and is granted round-robin. Operands are registered, the ALU is driven, and the result is presented on a single response channel tagged with the requester id.
- Adds signed-overflow and illegal-opcode flags, and holds the response until the consumer accepts it.

Parameters:
- DATA_W, 32, operand/result width (must stay 32 to match the ALU datapath).
- OP_W, 4, ALU opcode width.
- NREQ, 2, number of requesters; fixed at 2, round-robin logic sized for 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; a request transfers when valid&ready.
- req0_op, req1_op  in  4 each  ALU opcode per requester.
- req0_a, req0_b, req1_a, req1_b  in  32 each  operands A (RS) and B (RT).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that issued the response.
- rsp_result  out  32  ALU result.
- rsp_ovf  out  1  signed overflow (ADD/ADDI/SUB only).
- rsp_err  out  1  illegal opcode.

Behaviour:
- Reset (async assert, sync-style deassert use): rsp_valid=0, rsp_id=0, rsp_result=0, rsp_ovf=0, rsp_err=0, last_grant=1 (so port 0 wins the first contention), state=IDLE.
- State machine IDLE/HOLD:
  - IDLE -> HOLD on any grant.
  - HOLD -> IDLE on rsp_ready with no new grant.
  - HOLD -> HOLD on rsp_ready with a new grant, or when rsp_ready=0.
- can_accept = (state==IDLE) | rsp_ready. Back-to-back throughput is 1 op/cycle when rsp_ready is held high.
- Grant rule:
  - Only one port is granted per cycle.
  - If both are valid, the port != last_grant wins; if one is valid, it wins.
  - req_ready[i] = can_accept & grant[i]. req_ready is combinational from req_valid, state and rsp_ready; it never depends on req_*_op or operands.
  - last_grant updates only on an actual transfer.
- Latency: a request accepted at edge N produces rsp_valid=1 with its result after edge N (visible in cycle N+1). All rsp_* fields are registered together.
- While rsp_valid=1 and rsp_ready=0, every rsp_* field is held stable. No new request is accepted and no response is dropped.
- Opcode map (ALUOp):
  - 0 ADD, 1 ADDI, 2 SUB, 3 AND, 4 ANDI, 5 OR, 6 SLL, 7 SRL, 8 SRA, 9 SLT.
  - 10-15 are illegal: result=0, rsp_err=1, rsp_ovf=0. The response is still produced, with normal handshake.
- Shift ops (6-8): A is the shift amount. The controller passes {27'b0, A[4:0]} to the ALU; upper A bits are ignored. SRA is arithmetic (sign fill), SRL fills with zeros.
- SLT is a signed compare; the result is 32'd1 or 32'd0.
- Overflow flag:
  - ADD/ADDI: ovf = (a[31]==b[31]) & (r[31]!=a[31]).
  - SUB: ovf = (a[31]!=b[31]) & (r[31]!=a[31]).
  - Result wraps modulo 2^32 regardless of ovf.
- Fairness: a continuously valid requester waits at most one grant of the other port.
- Reset mid-operation: a pending or held response is discarded, rsp_valid drops immediately, last_grant returns to 1.
- A requester may deassert req_valid before ready without penalty; there is no request-side stability requirement beyond the transfer cycle.

Decomposition:
- Shared package alu_pkg holds:
  - ALUOp localparams (OP_ADD..OP_SLT), OP_LAST=9, and the illegal-op check function.
  - DATA_W and the overflow function.
- Single sub-module instance: the existing ALU datapath (module ALU), driven from the registered operand/op stage. Arbitration, flags and response registers live in alu_arbiter.

Test Plan:
- Single port 0 ADD a=32'h7FFFFFFF, b=1, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=32'h80000000, rsp_ovf=1, rsp_err=0.
- Both ports valid every cycle for 6 cycles, rsp_ready=1 -> grants alternate 0,1,0,1,0,1; rsp_id sequence matches, one response per cycle.
- Port 1 SRA a=32'h00000024, b=32'hF0000000 -> shift 4 (upper A bits ignored), rsp_result=32'hFF000000, rsp_id=1.
- rsp_ready=0 for 3 cycles after the first response, both ports valid -> req_ready=2'b00 during the hold, rsp_* stable. On release, the next grant goes to the other port.
- Opcode 4'hC from port 0 -> rsp_result=0, rsp_err=1, rsp_ovf=0. Then SLT a=-1, b=1 -> rsp_result=1, rsp_err=0.
- Assert rst_n=0 while rsp_valid=1 and held -> rsp_valid=0 immediately. After release, first contention is won by port 0.
